// File: rtl/div12_chain_ctrl.sv
// div12_chain_ctrl
// Synchronous replacement for a cascade of LS92-style divide-by-12 ripple counters.
// Each stage follows the LS92 count code (qa toggle plus the 3-bit divide-by-6 B section)
// and advances on a clock enable. An idle/run/pause sequencer with start/stop/clear control
// drives the chain, and the block flags carries and whole-chain wrap-around.
//
// Ports
//   clk      system clock; all state changes on its rising edge
//   reset_n  asynchronous active-low reset
//   tick     count enable, honoured only while running
//   start    request IDLE/PAUSE -> RUN
//   stop     request RUN -> PAUSE
//   clr      synchronous clear of the chain, forces IDLE
//   oneshot  1 = return to IDLE after one full chain wrap
//   q        stage i at [4i+3:4i] as {qd,qc,qb,qa}
//   running  1 while in RUN
//   carry    carry[i] = stage i rolled 13 -> 0 on the last edge (stage i+1 advanced)
//   wrap     one-cycle pulse after the whole chain rolls from all-13 to all-0
module div12_chain_ctrl #(
  parameter int unsigned STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clr,
  input  logic                  oneshot,
  output logic [4*STAGES-1:0]   q,
  output logic                  running,
  output logic [STAGES-1:0]     carry,
  output logic                  wrap
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [4*STAGES-1:0]   q_d;
  logic [STAGES-1:0]     carry_d;
  logic [STAGES-1:0]     at13;
  logic [STAGES-1:0]     stage_en;
  logic                  chain;
  logic                  adv0;
  logic                  wrap_event;
  logic                  wrap_d;

  // LS92 code step: qa toggles; the B section steps only as qa falls 1 -> 0.
  function automatic logic [3:0] next_code(input logic [3:0] c);
    logic [3:0] n;
    n[0] = ~c[0];
    if (c[0]) begin
      n[1] = ~(c[1] | c[2]);
      n[2] = c[1];
      n[3] = c[3] ^ c[2];
    end else begin
      n[3:1] = c[3:1];
    end
    return n;
  endfunction

  always_comb begin
    adv0     = (state_q == StRun) && tick;
    at13     = '0;
    stage_en = '0;
    chain    = adv0;
    // A stage advances when stage 0 does and every lower stage sits at 13.
    for (int i = 0; i < int'(STAGES); i++) begin
      at13[i]     = (q[4*i +: 4] == 4'd13);
      stage_en[i] = chain;
      chain       = chain & at13[i];
    end
    wrap_event = chain;

    q_d     = q;
    carry_d = stage_en & at13;
    wrap_d  = wrap_event;
    for (int i = 0; i < int'(STAGES); i++) begin
      if (stage_en[i]) begin
        q_d[4*i +: 4] = next_code(q[4*i +: 4]);
      end
    end

    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) state_d = StRun;
      end
      StRun: begin
        if (stop) begin
          state_d = StPause;
        end else if (wrap_event && oneshot) begin
          state_d = StIdle;
        end
      end
      StPause: begin
        if (start && !stop) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase

    if (clr) begin
      state_d = StIdle;
      q_d     = '0;
      carry_d = '0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      q       <= '0;
      running <= 1'b0;
      carry   <= '0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      q       <= q_d;
      running <= (state_d == StRun);
      carry   <= carry_d;
      wrap    <= wrap_d;
    end
  end

endmodule

// File: tb/tb_div12_chain_ctrl.sv
module tb_div12_chain_ctrl;
  localparam int unsigned STAGES = 2;
  localparam int MOD = 144;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                tick, start, stop, clr, oneshot;
  logic [4*STAGES-1:0] q;
  logic                running;
  logic [STAGES-1:0]   carry;
  logic                wrap;

  div12_chain_ctrl #(.STAGES(STAGES)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .start   (start),
    .stop    (stop),
    .clr     (clr),
    .oneshot (oneshot),
    .q       (q),
    .running (running),
    .carry   (carry),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: the chain is a plain integer 0..143, state 0=idle 1=run 2=pause.
  int                cnt = 0;
  int                mst = 0;
  logic [STAGES-1:0] ecarry = '0;
  logic              ewrap = 1'b0;
  int                code_tab[12] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13};

  function automatic logic [4*STAGES-1:0] enc(input int v);
    logic [4*STAGES-1:0] e;
    int                  rest;
    logic [31:0]         cw;
    e    = '0;
    rest = v;
    for (int i = 0; i < int'(STAGES); i++) begin
      cw          = code_tab[rest % 12];
      e[4*i +: 4] = cw[3:0];
      rest        = rest / 12;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_update(input logic t, s, p, c, o);
    int pw;
    ecarry = '0;
    ewrap  = 1'b0;
    if (c) begin
      cnt = 0;
      mst = 0;
    end else begin
      if (mst == 1 && t) begin
        pw = 12;
        for (int i = 0; i < int'(STAGES); i++) begin
          if ((cnt + 1) % pw == 0) ecarry[i] = 1'b1;
          pw = pw * 12;
        end
        cnt   = (cnt + 1) % MOD;
        ewrap = (cnt == 0);
      end
      case (mst)
        0: if (s && !p) mst = 1;
        1: begin
          if (p) mst = 2;
          else if (ewrap && o) mst = 0;
        end
        default: if (s && !p) mst = 1;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"}, 32'(q), 32'(enc(cnt)));
    chk({tag, ".running"}, 32'(running), 32'(mst == 1));
    chk({tag, ".carry"}, 32'(carry), 32'(ecarry));
    chk({tag, ".wrap"}, 32'(wrap), 32'(ewrap));
  endtask

  task automatic step(input string tag, input logic t, s, p, c, o);
    tick = t; start = s; stop = p; clr = c; oneshot = o;
    @(posedge clk);
    model_update(t, s, p, c, o);
    #1;
    check_all(tag);
  endtask

  task automatic run_to(input string tag, input int target);
    int n = 0;
    while (cnt != target && n < 400) begin
      step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk({tag, ".reached"}, 32'(q), 32'(enc(target)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncar, nwrap, widx, c1_at_wrap;
    logic [4*STAGES-1:0] qcar;

    reset_n = 1'b0;
    tick = 0; start = 0; stop = 0; clr = 0; oneshot = 0;
    #2;
    check_all("reset");
    #10 reset_n = 1'b1;  // released at t=12, away from an edge

    // Code sequence; the tick coincident with start is ignored.
    step("start", 1, 1, 0, 0, 0);
    ncar = 0;
    qcar = '0;
    for (int i = 0; i < 12; i++) begin
      step("codeseq", 1, 0, 0, 0, 0);
      if (carry[0]) begin
        ncar++;
        qcar = q;
      end
    end
    chk("carry0_once", 32'(ncar), 32'd1);
    chk("carry0_q", 32'(qcar), 32'h10);

    // Full wrap from zero.
    step("clr", 0, 0, 0, 1, 0);
    step("start2", 0, 1, 0, 0, 0);
    nwrap = 0; widx = 0; c1_at_wrap = 0;
    for (int i = 1; i <= 144; i++) begin
      step("fullwrap", 1, 0, 0, 0, 0);
      if (wrap) begin
        nwrap++;
        widx = i;
        c1_at_wrap = int'(carry[1]);
      end
    end
    chk("wrap_once", 32'(nwrap), 32'd1);
    chk("wrap_cycle", 32'(widx), 32'd144);
    chk("carry1_with_wrap", 32'(c1_at_wrap), 32'd1);

    // Asynchronous reset mid-count, off-edge.
    run_to("to35", 41);
    chk("q_is_35", 32'(q), 32'h35);
    #3 reset_n = 1'b0;
    #1;
    chk("arst.q", 32'(q), 32'h0);
    chk("arst.running", 32'(running), 32'd0);
    #2 reset_n = 1'b1;
    #1;
    chk("arst_hold.q", 32'(q), 32'h0);
    chk("arst_hold.running", 32'(running), 32'd0);
    cnt = 0; mst = 0; ecarry = '0; ewrap = 1'b0;
    step("postrst", 1, 0, 0, 0, 0);

    // Oneshot: back to idle on the wrap, then hold at zero.
    step("os_start", 0, 1, 0, 0, 1);
    for (int n = 0; n < 200 && !ewrap; n++) step("oneshot", 1, 0, 0, 0, 1);
    chk("os.wrap", 32'(wrap), 32'd1);
    chk("os.running", 32'(running), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step("os_hold", 1, 0, 0, 0, 1);
      chk("os_hold.q0", 32'(q), 32'h0);
    end

    // Pause/resume with tick every third cycle.
    step("clr2", 0, 0, 0, 1, 0);
    step("gap_start", 0, 1, 0, 0, 0);
    for (int i = 0; i < 60 && cnt != 7; i++) step("gap", (i % 3) == 0, 0, 0, 0, 0);
    chk("gap.q09", 32'(q), 32'h09);
    step("gap_stop", 0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step("paused", (i % 3) == 0, 0, 0, 0, 0);
    chk("paused.q09", 32'(q), 32'h09);
    step("resume", 0, 1, 0, 0, 0);
    step("resume_tick", 1, 0, 0, 0, 0);
    chk("resume.q0a", 32'(q), 32'h0A);

    // Simultaneous events.
    step("ss_run", 1, 1, 1, 0, 0);
    chk("ss_run.running", 32'(running), 32'd0);
    step("ss_pause", 1, 1, 1, 0, 0);
    chk("ss_pause.running", 32'(running), 32'd0);
    step("resume2", 0, 1, 0, 0, 0);
    run_to("pre_clr", 30);
    step("clr_run", 1, 1, 0, 1, 0);
    chk("clr_run.q", 32'(q), 32'h0);
    chk("clr_run.running", 32'(running), 32'd0);
    step("ss_idle", 1, 1, 1, 0, 0);
    chk("ss_idle.running", 32'(running), 32'd0);
    step("start3", 0, 1, 0, 0, 0);
    run_to("to143", 143);
    step("stop_wrap", 1, 0, 1, 0, 0);
    chk("stop_wrap.q", 32'(q), 32'h0);
    chk("stop_wrap.wrap", 32'(wrap), 32'd1);
    chk("stop_wrap.running", 32'(running), 32'd0);
    step("from_pause", 1, 1, 0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 31) == 0, $urandom_range(0, 127) == 0,
           $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
